regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: register file address width.
REQ-002 Parameter DATA_WIDTH, default 32: register file data width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_a, req_b  input  1 each  requester A/B access request, held until granted.
REQ-006 we_a, we_b  input  1 each  1 = write, 0 = read; stable while the matching req is high.
REQ-007 addr_a, addr_b  input  ADDR_WIDTH each  target address; stable while req is high.
REQ-008 wdata_a, wdata_b  input  DATA_WIDTH each  write data; stable while req is high.
REQ-009 gnt_a, gnt_b  output  1 each  one-cycle grant pulse; the requester SHALL drop or renew req on the next cycle.
REQ-010 rdata_a, rdata_b  output  DATA_WIDTH each  read result, held until the next read for that requester.
REQ-011 rvalid_a, rvalid_b  output  1 each  one-cycle pulse qualifying rdata_x.
REQ-012 mem_addr  output  ADDR_WIDTH  register file address.
REQ-013 mem_wr_en, mem_rd_en  output  1 each  register file write and read enables.
REQ-014 mem_wdata  output  DATA_WIDTH  register file write data.
REQ-015 mem_rd_data  input  DATA_WIDTH  register file read data, registered inside the file with 1-cycle latency.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, CMD and RESP.
REQ-018 IDLE: if any req is high, the FSM SHALL select a winner and register its addr, wdata and we onto the mem_* outputs, then go to CMD; otherwise it SHALL stay in IDLE.
REQ-019 CMD: the FSM SHALL drive mem_wr_en = we or mem_rd_en = !we (exactly one high) and pulse gnt_x for the winner; a write SHALL then go to IDLE and a read SHALL go to RESP.
REQ-020 RESP: rdata_x SHALL capture mem_rd_data and rvalid_x SHALL pulse for the winner, then the FSM SHALL go to IDLE.
REQ-021 Latency: a write SHALL take 2 cycles from IDLE back to IDLE; a read SHALL take 3; rvalid SHALL assert 2 cycles after the CMD cycle begins.
REQ-022 mem_wr_en, mem_rd_en, gnt_x and rvalid_x SHALL be 0 in every state other than the one that drives them.
REQ-023 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last SHALL win; a single requester SHALL always win.
REQ-024 The last-granted pointer SHALL update only on a grant.
REQ-025 A requester SHALL NOT be starved: with both requests held continuously, grants SHALL alternate A, B, A, B.
REQ-026 Requests arriving during CMD or RESP SHALL be ignored until IDLE; nothing SHALL be queued.
REQ-027 At most one gnt and one rvalid SHALL be high in any cycle.

Reset
REQ-028 While rst is high, the FSM SHALL be in IDLE; all outputs, rdata_a and rdata_b SHALL be 0; the pointer SHALL favour A on the first tie.
REQ-029 An rst assertion in CMD or RESP SHALL abort the transaction immediately; no rvalid SHALL follow deassertion.
REQ-030 The first arbitration after reset deassertion SHALL occur in the first IDLE clock edge.

Configuration
REQ-031 Macro REGFILE_ARB_FIXED_PRIO_EN: when defined, requester A SHALL always win simultaneous requests and the pointer SHALL be removed; when undefined, round-robin per REQ-023 to REQ-025 SHALL apply.

Verification
REQ-032 Write then read: A writes 0xDEADBEEF to address 5, then reads address 5 -> gnt_a in the CMD cycles, rvalid_a 2 cycles after the second CMD, rdata_a = 0xDEADBEEF.
REQ-033 Contention: A and B both request reads after reset (A addr 1, B addr 2) -> A is granted first, then B; each rvalid carries its own address's data; gnt never overlaps.
REQ-034 Sustained contention: both requests held for 8 grants -> grant order A, B, A, B, ... (with the macro defined: A on every grant).
REQ-035 Write/read mix: A writes 0x1 to address 3 while B reads address 3 on the same cycle -> A wins, and B then reads 0x1.
REQ-036 Reset mid-read: rst pulsed during RESP -> rvalid stays 0, outputs = 0, next request is served normally.
REQ-037 Idle: no requests for 20 cycles -> busy = 0, mem_wr_en = mem_rd_en = 0 throughout.

Source files
------------

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester arbiter serialising accesses onto one register file port
// Ports: clk, rst (async, active-high); req_/we_/addr_/wdata_{a,b} requests in;
//        gnt_{a,b}, rdata_{a,b}, rvalid_{a,b} responses out; mem_addr, mem_wr_en, mem_rd_en,
//        mem_wdata to the file, mem_rd_data from it (1-cycle read latency); busy when not IDLE.
// Define REGFILE_ARB_FIXED_PRIO_EN to make A always win ties (no round-robin pointer).
module regfile_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
    state_t state, state_next;
    logic we, win, pick;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    assign pick = !req_a;
`else
    logic last;
    // pick = 1 selects B; on a tie the requester not granted last wins
    assign pick = (req_a && req_b) ? !last : !req_a;
    always_ff @(posedge clk or posedge rst)
        if (rst) last <= 1'b1;
        else if (state == CMD) last <= win;
`endif
    assign busy = state != IDLE;
    always_comb begin
        state_next = state;
        mem_wr_en  = 1'b0;
        mem_rd_en  = 1'b0;
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        case (state)
            IDLE: state_next = (req_a || req_b) ? CMD : IDLE;
            CMD: begin
                mem_wr_en  = we;
                mem_rd_en  = !we;
                gnt_a      = !win;
                gnt_b      = win;
                state_next = we ? IDLE : RESP;
            end
            default: state_next = IDLE;
        endcase
    end
    // rvalid is registered with rdata so it lands 2 cycles after CMD begins
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            we        <= 1'b0;
            win       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_a   <= '0;
            rdata_b   <= '0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
        end else begin
            state    <= state_next;
            rvalid_a <= state == RESP && !win;
            rvalid_b <= state == RESP && win;
            if (state == IDLE && (req_a || req_b)) begin
                win       <= pick;
                we        <= pick ? we_b : we_a;
                mem_addr  <= pick ? addr_b : addr_a;
                mem_wdata <= pick ? wdata_b : wdata_a;
            end
            if (state == RESP && !win) rdata_a <= mem_rd_data;
            if (state == RESP && win) rdata_b <= mem_rd_data;
        end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed self-checking bench for regfile_arbiter
module tb_regfile_arbiter;
    logic clk = 0, rst;
    logic req_a, req_b, we_a, we_b;
    logic [9:0] addr_a, addr_b, mem_addr;
    logic [31:0] wdata_a, wdata_b, rdata_a, rdata_b, mem_wdata, mem_rd_data;
    logic gnt_a, gnt_b, rvalid_a, rvalid_b, mem_wr_en, mem_rd_en, busy;
    logic [31:0] mem [1024];
    bit gq[$];
    logic [32:0] rq[$];
    logic ovl;
    int n_chk = 0, n_pass = 0;

    regfile_arbiter dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .mem_addr(mem_addr),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_wdata(mem_wdata),
        .mem_rd_data(mem_rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // serve requests until n grants; hold keeps reqs up between grants
    task automatic run(input int n, input bit hold);
        int g = 0;
        gq.delete();
        rq.delete();
        ovl = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if ((gnt_a && gnt_b) || (rvalid_a && rvalid_b)) ovl = 1;
            if (rvalid_a) rq.push_back({1'b0, rdata_a});
            if (rvalid_b) rq.push_back({1'b1, rdata_b});
            if (gnt_a) begin gq.push_back(1'b0); g++; if (!hold) req_a = 0; end
            if (gnt_b) begin gq.push_back(1'b1); g++; if (!hold) req_b = 0; end
            if (g >= n) begin req_a = 0; req_b = 0; end
            if (g >= n && !busy && !rvalid_a && !rvalid_b) break;
        end
        check("grant_count", g, n);
        check("no_overlap", ovl, 0);
    endtask

    function automatic logic [7:0] order();
        logic [7:0] o = 0;
        foreach (gq[i]) if (i < 8) o[i] = gq[i];
        return o;
    endfunction

    initial begin
        logic bad;
        for (int i = 0; i < 1024; i++) mem[i] = 0;
        rst = 1; req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {busy, gnt_a, gnt_b, rvalid_a, rvalid_b, mem_wr_en, mem_rd_en}, 0);
        check("rst_data", {mem_addr, mem_wdata, rdata_a, rdata_b}, 0);
        rst = 0;
        req_a = 1; we_a = 1; addr_a = 5; wdata_a = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_cmd", {busy, gnt_a, gnt_b, mem_wr_en, mem_rd_en}, 5'b11010);
        check("wr_addr", mem_addr, 5);
        check("wr_data", mem_wdata, 32'hDEADBEEF);
        req_a = 0;
        @(negedge clk);
        check("wr_done", {busy, gnt_a, mem_wr_en}, 0);
        req_a = 1; we_a = 0;
        @(negedge clk);
        check("rd_cmd", {busy, gnt_a, gnt_b, mem_rd_en, mem_wr_en}, 5'b11010);
        req_a = 0;
        @(negedge clk);
        check("rd_resp", {busy, gnt_a, rvalid_a, mem_rd_en}, 4'b1000);
        @(negedge clk);
        check("rd_rvalid", {busy, rvalid_a, rvalid_b}, 3'b010);
        check("rd_data", rdata_a, 32'hDEADBEEF);
        @(negedge clk);
        check("rd_pulse", {rvalid_a, rdata_a}, {1'b0, 32'hDEADBEEF});
        req_a = 1; we_a = 1; addr_a = 1; wdata_a = 32'h11;
        run(1, 0);
        req_a = 1; addr_a = 2; wdata_a = 32'h22;
        run(1, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        req_a = 1; we_a = 0; addr_a = 1; req_b = 1; we_b = 0; addr_b = 2;
        run(2, 0);
        check("cont_order", order(), 8'b10);
        check("cont_nrv", rq.size(), 2);
        check("cont_rv0", rq[0], {1'b0, 32'h11});
        check("cont_rv1", rq[1], {1'b1, 32'h22});
        req_a = 1; req_b = 1;
        run(8, 1);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        check("sust_order", order(), 8'h00);
`else
        check("sust_order", order(), 8'hAA);
`endif
        req_a = 1; we_a = 1; addr_a = 3; wdata_a = 32'h1;
        req_b = 1; we_b = 0; addr_b = 3;
        run(2, 0);
        check("mix_order", order(), 8'b10);
        check("mix_nrv", rq.size(), 1);
        check("mix_rv", rq[0], {1'b1, 32'h1});
        req_a = 1; we_a = 0; addr_a = 5;
        @(negedge clk);
        check("abort_gnt", gnt_a, 1);
        req_a = 0;
        @(negedge clk);
        check("abort_resp", busy, 1);
        rst = 1;
        #1;
        check("abort_ctrl", {busy, gnt_a, gnt_b, rvalid_a, rvalid_b, mem_wr_en, mem_rd_en}, 0);
        check("abort_data", {mem_addr, mem_wdata, rdata_a, rdata_b}, 0);
        @(negedge clk);
        rst = 0;
        bad = 0;
        repeat (3) begin @(negedge clk); bad |= rvalid_a | rvalid_b | busy; end
        check("abort_norv", bad, 0);
        req_b = 1; we_b = 0; addr_b = 2;
        run(1, 0);
        check("abort_next", rq.size() == 1 ? rq[0] : 33'h0, {1'b1, 32'h22});
        bad = 0;
        repeat (20) begin @(negedge clk); bad |= busy | mem_wr_en | mem_rd_en; end
        check("idle", bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
